// File: rtl/reorder_pingpong_ctrl_pkg.sv
// Shared definitions for the ping-pong bit-reversal reorder controller:
// bank-state encoding and address-width helper.
package reorder_pingpong_ctrl_pkg;

    localparam int unsigned NUM_BANKS = 2;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Number of index bits needed to address one frame (and to bit-reverse it).
    function automatic int unsigned bitrev_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic bank_writable(input bank_state_e s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

    function automatic logic bank_readable(input bank_state_e s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

endpackage

// File: rtl/reorder_pingpong_ctrl_dual_ram.sv
// Simple dual-port RAM, one write port and one read port, registered read
// (one cycle latency); maps onto inferred block RAM.
module dual_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/reorder_pingpong_ctrl.sv
// Ping-pong frame buffer that accepts FFT output in bit-reversed order and
// emits it in natural order through a 2-entry skid FIFO.
module reorder_pingpong_ctrl
    import reorder_pingpong_ctrl_pkg::*;
#(
    parameter int N     = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam int CW = bitrev_width(N);
    localparam int AW = CW + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [CW-1:0]    r_wr_cnt;
    logic [CW-1:0]    r_rd_cnt;
    logic             r_inflight;
    logic             r_inflight_last;
    logic [1:0]       r_fifo_occ;
    logic [WIDTH-1:0] r_fifo_data [2];
    logic             r_fifo_last [2];

    bank_state_e      w_bank_state [NUM_BANKS];
    logic [CW-1:0]    w_wr_cnt_rev;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;
    logic             w_wr_fire;
    logic             w_rd_issue;
    logic             w_pop;
    logic [2:0]       w_occ_after;
    logic [1:0]       w_push_slot;
    logic [WIDTH-1:0] w_ram_rdata;

    generate
        for (genvar gi = 0; gi < CW; gi++) begin : g_bitrev
            assign w_wr_cnt_rev[gi] = r_wr_cnt[CW-1-gi];
        end
    endgenerate

    assign in_ready  = bank_writable(w_bank_state[r_wr_bank]);
    assign w_wr_fire = in_valid && in_ready;
    assign w_wr_addr = {r_wr_bank, w_wr_cnt_rev};
    assign w_rd_addr = {r_rd_bank, r_rd_cnt};

    assign out_valid = (r_fifo_occ != 2'd0);
    assign out_data  = r_fifo_data[0];
    assign out_last  = r_fifo_last[0] && out_valid;
    assign w_pop     = out_valid && out_ready;

    // Occupancy the FIFO will hold once this cycle's return and pop settle;
    // a new read may only be issued if its data is guaranteed a slot.
    assign w_occ_after = 3'(r_fifo_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_rd_issue  = bank_readable(w_bank_state[r_rd_bank]) && (w_occ_after < 3'd2);
    assign w_push_slot = r_fifo_occ - 2'(w_pop);

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            bank_state_e r_state;
            logic        w_wr_hit;
            logic        w_rd_hit;

            assign w_wr_hit = w_wr_fire && (r_wr_bank == 1'(gi));
            assign w_rd_hit = w_rd_issue && (r_rd_bank == 1'(gi));

            // Writes and reads never hit the same bank in one cycle: the
            // writable and readable state sets are disjoint.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_state <= BANK_EMPTY;
                end else if (w_wr_hit) begin
                    r_state <= (r_wr_cnt == LAST_CNT) ? BANK_FULL : BANK_FILLING;
                end else if (w_rd_hit) begin
                    r_state <= (r_rd_cnt == LAST_CNT) ? BANK_EMPTY : BANK_DRAINING;
                end
            end

            assign w_bank_state[gi] = r_state;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
        end else if (w_wr_fire) begin
            if (r_wr_cnt == LAST_CNT) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_cnt <= r_wr_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_bank       <= 1'b0;
            r_rd_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_rd_issue;
            r_inflight_last <= w_rd_issue && (r_rd_cnt == LAST_CNT);
            if (w_rd_issue) begin
                if (r_rd_cnt == LAST_CNT) begin
                    r_rd_cnt  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_cnt <= r_rd_cnt + CW'(1);
                end
            end
        end
    end

    // Shift FIFO: entry 0 is always the head. The push lands after any shift,
    // so a push into slot 0 deliberately overrides the shifted value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fifo_occ     <= 2'd0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last[0] <= 1'b0;
            r_fifo_last[1] <= 1'b0;
        end else begin
            if (w_pop) begin
                r_fifo_data[0] <= r_fifo_data[1];
                r_fifo_last[0] <= r_fifo_last[1];
            end
            if (r_inflight) begin
                if (w_push_slot == 2'd0) begin
                    r_fifo_data[0] <= w_ram_rdata;
                    r_fifo_last[0] <= r_inflight_last;
                end else begin
                    r_fifo_data[1] <= w_ram_rdata;
                    r_fifo_last[1] <= r_inflight_last;
                end
            end
            r_fifo_occ <= w_occ_after[1:0];
        end
    end

    dual_ram #(
        .WIDTH (WIDTH),
        .DEPTH (2 * N),
        .AW    (AW)
    ) u_dual_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_fire),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (in_data),
        .i_rd_en   (w_rd_issue),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_rdata)
    );

endmodule

// File: tb/tb_reorder_pingpong_ctrl.sv
// Directed bench for reorder_pingpong_ctrl (N=16): frame words are {frame, natural index},
// fed in bit-reversed order and checked against an in-order expected queue.
module tb_reorder_pingpong_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int ready_mode   = 0;   // 0: held high, 1: held low, 2: random 50%
    int first_out_cyc, first_pop_cyc, last_pop_cyc;
    int out_count, last_count, acc_count, stall_count, last_acc_edge;
    logic [31:0] exp_q [$];

    reorder_pingpong_ctrl #(.N(16), .WIDTH(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bitrev4(input int k);
        logic [3:0] v;
        v = 4'(k);
        return int'({v[0], v[1], v[2], v[3]});
    endfunction

    function automatic logic [31:0] word(input int f, input int n);
        return {16'(f), 16'(n)};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        first_out_cyc = -1;
        first_pop_cyc = -1;
        last_pop_cyc  = -1;
        out_count     = 0;
        last_count    = 0;
        acc_count     = 0;
        stall_count   = 0;
    endtask

    // Called just after a rising edge; offers d until accepted or budget expires.
    task automatic try_send(input logic [31:0] d, input bit rnd, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data  = in_valid ? d : $urandom;
            @(negedge clk);
            if (in_valid && in_ready) begin
                ok            = 1'b1;
                acc_count++;
                last_acc_edge = cyc + 1;
            end else if (in_valid) begin
                stall_count++;
            end
            step();
        end
    endtask

    task automatic send_frame(input int f, input bit rnd);
        bit ok;
        for (int k = 0; k < 16; k++) begin
            try_send(word(f, bitrev4(k)), rnd, 3000, ok);
            if (!ok) begin
                tests_run++;
                tests_failed++;
                $error("FAIL send_timeout: frame %0d sample %0d not accepted", f, k);
                return;
            end
        end
        for (int n = 0; n < 16; n++) exp_q.push_back(word(f, n));
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 5000) begin
            step();
            t++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            step();
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Output monitor: in-order scoreboard plus timing bookkeeping.
    initial begin
        logic [31:0] exp_word;
        forever begin
            @(negedge clk);
            if (rstn && out_valid) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $error("FAIL unexpected_out: observed %0h, expected no output", out_data);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check("out_data", out_data, exp_word);
                        check("out_last", 32'(out_last), 32'(exp_word[15:0] == 16'd15));
                    end
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    out_count++;
                    if (out_last) begin
                        last_count++;
                        $display("[TB] frame %0d out, last sample at cycle %0d", out_data[31:16], cyc);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clear_stats();

        // Reset state, before any clock edge and after release.
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        repeat (3) step();
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready",  32'(in_ready),  32'd1);
        step();

        // Single frame: data bitrev(k) comes out as 0..15, latency 2.
        clear_stats();
        send_frame(0, 1'b0);
        in_valid = 1'b0;
        wait_drain("t1_drain");
        check("t1_latency", 32'(first_out_cyc - last_acc_edge), 32'd2);
        check("t1_count",   32'(out_count),  32'd16);
        check("t1_lasts",   32'(last_count), 32'd1);

        // Four back-to-back frames at full rate.
        clear_stats();
        for (int f = 1; f <= 4; f++) send_frame(f, 1'b0);
        in_valid = 1'b0;
        wait_drain("t2_drain");
        check("t2_in_stalls", 32'(stall_count), 32'd0);
        check("t2_count",     32'(out_count),   32'd64);
        check("t2_no_gap",    32'(last_pop_cyc - first_pop_cyc), 32'd63);
        check("t2_lasts",     32'(last_count),  32'd4);

        // Downstream stalled for ~40 cycles while three frames are offered.
        clear_stats();
        ready_mode = 1;
        step();
        step();
        send_frame(5, 1'b0);
        send_frame(6, 1'b0);
        try_send(word(7, 0), 1'b0, 8, ok);
        check("t3_blocked", 32'(ok), 32'd0);
        @(negedge clk);
        check("t3_accepts",   32'(acc_count), 32'd32);
        check("t3_in_ready",  32'(in_ready),  32'd0);
        check("t3_out_valid", 32'(out_valid), 32'd1);
        check("t3_head_data", out_data,       word(5, 0));
        check("t3_head_last", 32'(out_last),  32'd0);
        step();
        ready_mode = 0;
        send_frame(7, 1'b0);
        in_valid = 1'b0;
        wait_drain("t3_drain");
        check("t3_count", 32'(out_count),  32'd48);
        check("t3_lasts", 32'(last_count), 32'd3);

        // Random valid / ready, 100 frames.
        clear_stats();
        ready_mode = 2;
        for (int f = 8; f < 108; f++) send_frame(f, 1'b1);
        in_valid = 1'b0;
        wait_drain("t4_drain");
        check("t4_count", 32'(out_count),  32'd1600);
        check("t4_lasts", 32'(last_count), 32'd100);
        ready_mode = 0;
        step();
        step();

        // Reset pulse with frame 109 partially written (wr_cnt = 7).
        clear_stats();
        send_frame(108, 1'b0);
        for (int k = 0; k < 7; k++) begin
            try_send(word(109, bitrev4(k)), 1'b0, 100, ok);
            check("t5_pre_accept", 32'(ok), 32'd1);
        end
        rstn     = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_in_ready",  32'(in_ready),  32'd1);
        check("t5_rst_out_last",  32'(out_last),  32'd0);
        check("t5_rst_out_data",  out_data,       32'd0);
        step();
        rstn = 1'b1;
        step();
        @(negedge clk);
        check("t5_post_out_valid", 32'(out_valid), 32'd0);
        step();
        clear_stats();
        send_frame(110, 1'b0);
        in_valid = 1'b0;
        wait_drain("t5_drain");
        check("t5_count", 32'(out_count),  32'd16);
        check("t5_lasts", 32'(last_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reorder_pingpong_ctrl.md
REORDER_PINGPONG_CTRL -- requirements
Module: reorder_pingpong_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, FFT frame length in samples, power of two, 4..4096.
REQ-002 SHALL have parameter WIDTH, default 32, sample width (packed re/im).
REQ-003 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, input sample valid.
REQ-006 SHALL have port in_ready, output, 1, controller accepts input sample.
REQ-007 SHALL have port in_data, input, WIDTH, sample in bit-reversed frame order.
REQ-008 SHALL have port out_valid, output, 1, output sample valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts output sample.
REQ-010 SHALL have port out_data, output, WIDTH, sample in natural frame order.
REQ-011 SHALL have port out_last, output, 1, high with natural index N-1 of each frame.

Function
REQ-012 SHALL store frames in a dual_ram of DEPTH 2N, split into bank 0 (addresses 0..N-1) and bank 1 (N..2N-1).
REQ-013 SHALL keep a per-bank state: EMPTY -> FILLING (first write) -> FULL (write of count N-1) -> DRAINING (first read) -> EMPTY (read of count N-1).
REQ-014 SHALL accept input when in_valid && in_ready; in_ready = bank[wr_bank] in {EMPTY, FILLING}.
REQ-015 SHALL write accepted sample k of a frame (k = wr_cnt, 0..N-1) to address {wr_bank, bitrev(k)}; wr_bank toggles and wr_cnt returns to 0 after k = N-1.
REQ-016 SHALL issue a read when bank[rd_bank] in {FULL, DRAINING} and (fifo_occ + inflight - pop) < 2, at address {rd_bank, rd_cnt}; rd_cnt increments and rd_bank toggles after rd_cnt = N-1.
REQ-017 SHALL treat read latency as 1 cycle; returned data enters a 2-entry output FIFO, with out_last tagged from rd_cnt = N-1 at issue.
REQ-018 SHALL present FIFO head on out_data/out_valid; pop on out_valid && out_ready; no data loss or duplication under any out_ready pattern.
REQ-019 SHALL sustain 1 sample/cycle in and out when in_valid and out_ready are held high; first output appears 2 cycles after the last input of frame 0 is accepted.
REQ-020 SHALL update bank state from registered state only: a bank freed by a read in cycle t is writable from cycle t+1; a bank filled in cycle t is readable from cycle t+1.
REQ-021 SHALL never write into a FULL or DRAINING bank; with both banks occupied, in_ready = 0 until one bank returns to EMPTY.
REQ-022 SHALL ignore in_data when in_valid = 0 and hold out_data/out_last stable while out_valid && !out_ready.

Reset
REQ-023 SHALL, on rstn low, asynchronously clear both bank states to EMPTY, wr_bank, rd_bank, wr_cnt, rd_cnt, inflight, and FIFO occupancy to 0.
REQ-024 SHALL drive out_valid = 0, out_last = 0, out_data = 0, in_ready = 1 during and after reset; RAM contents need not be cleared.
REQ-025 SHALL discard any partial frame and pending reads on reset mid-operation; the first frame after reset starts at wr_cnt = 0.

Structure
REQ-026 SHALL place the bank-state enumeration and the bitrev width helper in the shared fft package.
REQ-027 SHALL instantiate exactly one sub-module, dual_ram (WIDTH, DEPTH = 2N); FIFO and FSMs stay inline.

Verification
REQ-028 SHALL cover: N=16, frame in_data = bitrev(k) for k = 0..15, out_ready = 1 -> out_data 0..15, out_last on 15, first out 2 cycles after last in.
REQ-029 SHALL cover: 4 back-to-back frames with out_ready = 1 -> in_ready stays 1, 64 outputs, no gap after the first frame.
REQ-030 SHALL cover: out_ready = 0 for 40 cycles while 3 frames are offered -> in_ready falls after 32 accepts, out FIFO holds 2, no loss after release.
REQ-031 SHALL cover: out_ready random 50%, in_valid random 50%, 100 frames -> output equals scoreboard natural order, out_last every 16th.
REQ-032 SHALL cover: rstn pulse at wr_cnt = 7 of frame 1 -> out_valid = 0 next cycle, in_ready = 1, next frame reorders correctly.
